// File: rtl/vga_text_scan.sv
// 640x480@60 timing and text-mode address generator for an 80x30 character display.
// Stage 0 drives the text RAM address; sync/blank/column are delayed to meet the glyph ROM output.
module vga_text_scan #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned COLS      = 80
) (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] text_addr,
  output logic [3:0]  chr_row,
  output logic [2:0]  chr_col,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS_C  = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS_C  = 10'(V_VISIBLE);
  localparam logic [9:0]  HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [11:0] COLS_C   = 12'(COLS);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  logic       visible0, hs0, vs0;

  logic [3:0] row1_q;
  logic [2:0] col1_q, col2_q;
  logic       hs1_q, hs2_q;
  logic       vs1_q, vs2_q;
  logic       vis1_q, vis2_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  always_comb begin
    visible0    = (h_q < H_VIS_C) && (v_q < V_VIS_C);
    hs0         = !((h_q >= HS_START) && (h_q < HS_END));
    vs0         = !((v_q >= VS_START) && (v_q < VS_END));
    frame_start = (h_q == '0) && (v_q == '0);
    text_addr   = '0;
    // Address is forced to 0 in blanking so it never leaves the 0..COLS*30-1 window.
    if (visible0) begin
      text_addr = 12'(v_q[9:4]) * COLS_C + 12'(h_q[9:3]);
    end
  end

  // Sync registers reset to the inactive (high) level so release emits no stray pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row1_q <= '0;
      col1_q <= '0;
      col2_q <= '0;
      hs1_q  <= 1'b1;
      hs2_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vs2_q  <= 1'b1;
      vis1_q <= 1'b0;
      vis2_q <= 1'b0;
    end else begin
      row1_q <= v_q[3:0];
      col1_q <= h_q[2:0];
      col2_q <= col1_q;
      hs1_q  <= hs0;
      hs2_q  <= hs1_q;
      vs1_q  <= vs0;
      vs2_q  <= vs1_q;
      vis1_q <= visible0;
      vis2_q <= vis1_q;
    end
  end

  assign chr_row  = row1_q;
  assign chr_col  = col2_q;
  assign hsync    = hs2_q;
  assign vsync    = vs2_q;
  assign video_on = vis2_q;

endmodule

// File: tb/tb_vga_text_scan.sv
// Bench for vga_text_scan: full-size instance for address/alignment points, a shrunken
// geometry instance for whole-frame sync statistics and mid-frame reset.
module tb_vga_text_scan;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, cols;
  } geom_t;

  geom_t ga = '{640, 16, 96, 48, 480, 10, 2, 33, 80};
  geom_t gb = '{64, 4, 8, 4, 48, 2, 2, 3, 8};

  logic clk = 1'b0;
  logic rst_a, rst_b;

  logic [11:0] a_addr, b_addr;
  logic [3:0]  a_row, b_row;
  logic [2:0]  a_col, b_col;
  logic        a_hs, a_vs, a_vo, a_fs;
  logic        b_hs, b_vs, b_vo, b_fs;

  int n_checks = 0;
  int n_pass   = 0;
  int na = 0;
  int nb = 0;

  always #5 clk = ~clk;

  vga_text_scan dut_a (
    .clk(clk), .rst(rst_a), .text_addr(a_addr), .chr_row(a_row), .chr_col(a_col),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo), .frame_start(a_fs)
  );

  vga_text_scan #(
    .H_VISIBLE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(48), .V_FP(2), .V_SYNC(2), .V_BP(3), .COLS(8)
  ) dut_b (
    .clk(clk), .rst(rst_b), .text_addr(b_addr), .chr_row(b_row), .chr_col(b_col),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo), .frame_start(b_fs)
  );

  // Clock edges since reset release: the counters must equal this index modulo the frame.
  always @(posedge clk or posedge rst_a) if (rst_a) na <= 0; else na <= na + 1;
  always @(posedge clk or posedge rst_b) if (rst_b) nb <= 0; else nb <= nb + 1;

  function automatic logic [7:0] romf(input logic [7:0] c, input logic [3:0] r);
    return c ^ {r, r};
  endfunction

  // Bench-side 1-cycle text RAM (returns addr[7:0]) feeding a 1-cycle glyph ROM.
  logic [7:0] ram_a, rom_a, ram_b, rom_b;
  always @(posedge clk) begin
    ram_a <= a_addr[7:0];
    rom_a <= romf(ram_a, a_row);
    ram_b <= b_addr[7:0];
    rom_b <= romf(ram_b, b_row);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int htot(input geom_t g); return g.hv + g.hf + g.hs + g.hb; endfunction
  function automatic int vtot(input geom_t g); return g.vv + g.vf + g.vs + g.vb; endfunction
  function automatic int hpos(input geom_t g, input int k); return k % htot(g); endfunction
  function automatic int vpos(input geom_t g, input int k); return (k / htot(g)) % vtot(g); endfunction
  function automatic bit vis(input geom_t g, input int k);
    return (hpos(g, k) < g.hv) && (vpos(g, k) < g.vv);
  endfunction
  function automatic int addr_at(input geom_t g, input int k);
    return vis(g, k) ? (vpos(g, k) / 16) * g.cols + hpos(g, k) / 8 : 0;
  endfunction

  task automatic check_inst(input geom_t g, input int n, input string t,
                            input logic [11:0] ad, input logic fs, input logic [3:0] rw,
                            input logic [2:0] cl, input logic hs, input logic vs,
                            input logic vo, input logic [7:0] rq);
    int h2, v2;
    logic [7:0] er;
    chk({t, "_addr"}, int'(ad), addr_at(g, n));
    chk({t, "_fs"}, int'(fs), int'(hpos(g, n) == 0 && vpos(g, n) == 0));
    chk({t, "_row"}, int'(rw), (n >= 1) ? vpos(g, n - 1) % 16 : 0);
    if (n >= 2) begin
      h2 = hpos(g, n - 2);
      v2 = vpos(g, n - 2);
      chk({t, "_col"}, int'(cl), h2 % 8);
      chk({t, "_hsync"}, int'(hs), int'(!(h2 >= g.hv + g.hf && h2 < g.hv + g.hf + g.hs)));
      chk({t, "_vsync"}, int'(vs), int'(!(v2 >= g.vv + g.vf && v2 < g.vv + g.vf + g.vs)));
      chk({t, "_video"}, int'(vo), int'(vis(g, n - 2)));
      er = romf(8'(addr_at(g, n - 2)), 4'(v2 % 16));
      chk({t, "_rom"}, int'(rq), int'(er));
      chk({t, "_pix"}, int'(rq[cl]), int'(er[h2 % 8]));
    end else begin
      chk({t, "_col"}, int'(cl), 0);
      chk({t, "_hsync"}, int'(hs), 1);
      chk({t, "_vsync"}, int'(vs), 1);
      chk({t, "_video"}, int'(vo), 0);
    end
  endtask

  int hs_falls = 0, hs_low = 0, vs_low = 0, vo_high = 0, fs_cnt = 0;
  logic prev_hs = 1'b1;
  bit stats_done = 0;

  always @(negedge clk) begin
    check_inst(ga, na, "A", a_addr, a_fs, a_row, a_col, a_hs, a_vs, a_vo, rom_a);
    check_inst(gb, nb, "B", b_addr, b_fs, b_row, b_col, b_hs, b_vs, b_vo, rom_b);

    if (!rst_a) begin
      if (na == 640)   chk("addr_h640_v0", int'(a_addr), 0);
      if (na == 12008) chk("addr_h8_v15", int'(a_addr), 1);
      if (na == 12800) chk("addr_h0_v16", int'(a_addr), 80);
      if (na == 28017) chk("addr_h17_v35", int'(a_addr), 162);
      if (na == 28018) chk("row_h17_v35", int'(a_row), 3);
      if (na == 28019) begin
        chk("col_h17_v35", int'(a_col), 1);
        chk("rom_h17_v35", int'(rom_a), 8'h91);
      end
    end

    if (!rst_b) begin
      if (nb == 3823) chk("B_addr_last_cell", int'(b_addr), 23);
      if (nb == 69)   chk("B_hs_before_fall", int'(b_hs), 1);
      if (nb == 70)   chk("B_hs_fall", int'(b_hs), 0);
      if (nb == 77)   chk("B_hs_last_low", int'(b_hs), 0);
      if (nb == 78)   chk("B_hs_rise", int'(b_hs), 1);
      if (nb == 4001) chk("B_vs_before_fall", int'(b_vs), 1);
      if (nb == 4002) chk("B_vs_fall", int'(b_vs), 0);
      if (nb == 4161) chk("B_vs_last_low", int'(b_vs), 0);
      if (nb == 4162) chk("B_vs_rise", int'(b_vs), 1);
      if (!stats_done && nb < 4400) begin
        if (!b_hs) hs_low++;
        if (prev_hs && !b_hs) hs_falls++;
        if (!b_vs) vs_low++;
        if (b_vo) vo_high++;
        if (b_fs) fs_cnt++;
        prev_hs = b_hs;
      end
      if (nb == 4400) begin
        if (!stats_done) begin
          chk("B_fs_frame_end", int'(b_fs), 1);
          chk("B_hs_pulses", hs_falls, 55);
          chk("B_hs_low_clocks", hs_low, 440);
          chk("B_vs_low_clocks", vs_low, 160);
          chk("B_video_clocks", vo_high, 3072);
          chk("B_fs_inside_frame", fs_cnt, 0);
          stats_done = 1;
        end else begin
          chk("B_fs_after_reset", int'(b_fs), 1);
        end
      end
    end
  end

  task automatic wait_n(input bit which_b, input int target, input int budget);
    int k = 0;
    while ((which_b ? nb : na) != target && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(which_b ? "B_wait_timeout" : "A_wait_timeout", which_b ? nb : na, target);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    #22;
    rst_a = 1'b0;
    rst_b = 1'b0;

    wait_n(1'b1, 4402, 5000);
    wait_n(1'b1, 6030, 3000);
    // Counter now at h=30, v=20 of the second frame; reset lands between edges.
    #1 rst_b = 1'b1;
    #1;
    chk("async_addr", int'(b_addr), 0);
    chk("async_fs", int'(b_fs), 1);
    chk("async_row", int'(b_row), 0);
    chk("async_col", int'(b_col), 0);
    chk("async_hsync", int'(b_hs), 1);
    chk("async_vsync", int'(b_vs), 1);
    chk("async_video", int'(b_vo), 0);
    repeat (3) @(posedge clk);
    #2 rst_b = 1'b0;

    wait_n(1'b1, 4402, 5000);
    wait_n(1'b0, 28022, 30000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
